// File: rtl/wdog_osc_ctrl_if.sv
// Control/status bundle between the watchdog-oscillator controller and its host.
// The oscillator clock rides along so the analog macro hookup stays in one place.
interface wdog_osc_ctrl_if;
  logic        i_en;
  logic        i_kick;
  logic        i_clr;
  logic [15:0] i_timeout;
  logic        i_osc_clk;
  logic        o_osc_pd;
  logic        o_osc_ok;
  logic        o_wdt_expired;
  logic        o_fault;
  logic [15:0] o_wdt_count;

  modport master (
    output i_en, i_kick, i_clr, i_timeout, i_osc_clk,
    input  o_osc_pd, o_osc_ok, o_wdt_expired, o_fault, o_wdt_count
  );

  modport slave (
    input  i_en, i_kick, i_clr, i_timeout, i_osc_clk,
    output o_osc_pd, o_osc_ok, o_wdt_expired, o_fault, o_wdt_count
  );
endinterface

// File: rtl/wdog_osc_ctrl.sv
// 800 kHz watchdog oscillator sequencer: power-up, settle, frequency check,
// then a watchdog counted in oscillator edges with stall detection.
module wdog_osc_ctrl #(
  parameter int SETTLE_CYC = 64,
  parameter int WIN_CYC    = 1250,
  parameter int EDGE_MIN   = 8,
  parameter int EDGE_MAX   = 12,
  parameter int STALL_CYC  = 250
) (
  input  logic           i_clk,
  input  logic           i_rst,
  wdog_osc_ctrl_if.slave bus
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int WW = $clog2(WIN_CYC + 1);
  localparam int TW = $clog2(STALL_CYC + 1);

  typedef enum logic [2:0] {S_OFF, S_STARTUP, S_CHECK, S_RUN, S_EXPIRED, S_FAULT} state_t;

  state_t        state, state_d;
  logic          sync1, sync2, hist, edge_det;
  logic [SW-1:0] settle_cnt, settle_d;
  logic [WW-1:0] win_cnt, win_d;
  logic [7:0]    edge_cnt, edge_d, edge_nxt;
  logic [TW-1:0] stall_cnt, stall_d;
  logic [15:0]   wdt_cnt, wdt_d, reload;
  logic          pd_q, pd_d, ok_q, ok_d, exp_q, exp_d, fault_q, fault_d;
  logic          clr_cnt, in_range;

  assign reload   = (bus.i_timeout == 16'd0) ? 16'd1 : bus.i_timeout;
  assign edge_nxt = (edge_det && edge_cnt != 8'hFF) ? edge_cnt + 8'd1 : edge_cnt;
  assign in_range = (edge_nxt >= 8'(EDGE_MIN)) && (edge_nxt <= 8'(EDGE_MAX));

  assign bus.o_osc_pd      = pd_q;
  assign bus.o_osc_ok      = ok_q;
  assign bus.o_wdt_expired = exp_q;
  assign bus.o_fault       = fault_q;
  assign bus.o_wdt_count   = wdt_cnt;

  // pd resets high asynchronously so the macro powers down with no clock running
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      hist       <= 1'b0;
      edge_det   <= 1'b0;
      state      <= S_OFF;
      settle_cnt <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      stall_cnt  <= '0;
      wdt_cnt    <= '0;
      pd_q       <= 1'b1;
      ok_q       <= 1'b0;
      exp_q      <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      sync1      <= bus.i_osc_clk;
      sync2      <= sync1;
      hist       <= sync2;
      edge_det   <= sync2 & ~hist;
      state      <= state_d;
      settle_cnt <= settle_d;
      win_cnt    <= win_d;
      edge_cnt   <= edge_d;
      stall_cnt  <= stall_d;
      wdt_cnt    <= wdt_d;
      pd_q       <= pd_d;
      ok_q       <= ok_d;
      exp_q      <= exp_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d  = state;
    settle_d = settle_cnt;
    win_d    = win_cnt;
    edge_d   = edge_cnt;
    stall_d  = stall_cnt;
    wdt_d    = wdt_cnt;
    pd_d     = pd_q;
    ok_d     = ok_q;
    exp_d    = exp_q;
    fault_d  = fault_q;
    clr_cnt  = 1'b0;

    unique case (state)
      S_OFF: begin
        pd_d = 1'b1;
        ok_d = 1'b0;
        if (bus.i_en) begin
          state_d = S_STARTUP;
          pd_d    = 1'b0;
          clr_cnt = 1'b1;
        end
      end
      S_STARTUP: begin
        if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
          state_d = S_CHECK;
          win_d   = '0;
          edge_d  = '0;
        end else begin
          settle_d = settle_cnt + SW'(1);
        end
      end
      S_CHECK: begin
        if (win_cnt == WW'(WIN_CYC - 1)) begin
          if (in_range) begin
            state_d = S_RUN;
            ok_d    = 1'b1;
            wdt_d   = reload;
            stall_d = '0;
          end else begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            pd_d    = 1'b1;
            ok_d    = 1'b0;
          end
        end else begin
          win_d  = win_cnt + WW'(1);
          edge_d = edge_nxt;
        end
      end
      S_RUN: begin
        if (!edge_det && stall_cnt == TW'(STALL_CYC - 1)) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          pd_d    = 1'b1;
          ok_d    = 1'b0;
        end else begin
          stall_d = edge_det ? '0 : stall_cnt + TW'(1);
          // a kick landing with an edge reloads and swallows the decrement
          if (bus.i_kick) begin
            wdt_d = reload;
          end else if (edge_det) begin
            if (wdt_cnt == 16'd1) begin
              wdt_d   = '0;
              state_d = S_EXPIRED;
              exp_d   = 1'b1;
            end else begin
              wdt_d = wdt_cnt - 16'd1;
            end
          end
        end
      end
      S_EXPIRED: begin
        if (bus.i_clr) begin
          state_d = S_RUN;
          wdt_d   = reload;
          exp_d   = 1'b0;
          stall_d = '0;
        end
      end
      S_FAULT: begin
        if (bus.i_clr) begin
          state_d = S_OFF;
          fault_d = 1'b0;
          clr_cnt = 1'b1;
        end
      end
      default: state_d = S_OFF;
    endcase

    // dropping enable overrides whatever the active states decided above
    if ((state inside {S_STARTUP, S_CHECK, S_RUN, S_EXPIRED}) && !bus.i_en) begin
      state_d = S_OFF;
      pd_d    = 1'b1;
      ok_d    = 1'b0;
      exp_d   = 1'b0;
      fault_d = 1'b0;
      clr_cnt = 1'b1;
    end

    if (clr_cnt) begin
      settle_d = '0;
      win_d    = '0;
      edge_d   = '0;
      stall_d  = '0;
      wdt_d    = '0;
    end
  end
endmodule
